// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and the store lane-merge helper for mem_responder
package mem_resp_pkg;

   typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_BAD} size_e;

   typedef enum logic [2:0] {IDLE, RD_WAIT, RMW_RD, RMW_WR, WR, RESP} state_e;

   // Little-endian lane placement: byte lane = addr[1:0], half lane = addr[1]
   function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input size_e sz, input logic [1:0] lane);
      logic [4:0] sh;
      logic [31:0] m;
      sh = (sz == SZ_HALF) ? {lane[1], 4'b0} : (sz == SZ_BYTE) ? {lane, 3'b0} : 5'd0;
      m = (sz == SZ_BYTE) ? 32'hFF << sh : (sz == SZ_HALF) ? 32'hFFFF << sh : '1;
      return (old & ~m) | ((wd << sh) & m);
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: 1R/1W synchronous word RAM, write-first on a same-word collision
module mem_resp_array #(
   parameter int    DEPTH_LOG2 = 8,
   parameter string INIT_FILE  = ""
) (
   input  logic                  clock,
   input  logic [DEPTH_LOG2-1:0] rd_addr,
   output logic [31:0]           rd_data,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] wr_addr,
   input  logic [31:0]           wr_data
);

   logic [31:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: handshaked, wait-stated word/half/byte memory responder with RMW sub-word stores
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int    DEPTH_LOG2 = 8,
   parameter int    READ_WAIT  = 2,
   parameter string INIT_FILE  = ""
) (
   input  logic        clock,
   input  logic        reset_l,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = DEPTH_LOG2 + 2;
   localparam logic [3:0] RW = 4'(READ_WAIT);

   state_e              state;
   size_e               size_q;
   logic [AW-1:0]       addr_q;
   logic [31:0]         wdata_q;
   logic [3:0]          cnt;
   logic [31:0]         q, rs, rd_val, wd;
   logic [DEPTH_LOG2-1:0] ra;
   logic [4:0]          sh;
   logic                we, bad;

   assign bad = (req_size == 2'b11) || (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
                (req_size == 2'b01 && req_addr[0]) || (req_addr[31:AW] != '0);

   // The read is launched at the accept edge so the word is ready one cycle later
   assign ra = (state == IDLE) ? req_addr[AW-1:2] : addr_q[AW-1:2];
   assign we = (state == WR) || (state == RMW_WR);
   assign wd = (state == WR) ? wdata_q : lane_merge(q, wdata_q, size_q, addr_q[1:0]);

   assign sh = (size_q == SZ_HALF) ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
   assign rs = q >> sh;
   assign rd_val = (size_q == SZ_WORD) ? q : (size_q == SZ_HALF) ? {16'b0, rs[15:0]} : {24'b0, rs[7:0]};

   mem_resp_array #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE(INIT_FILE)) u_array (
      .clock  (clock),
      .rd_addr(ra),
      .rd_data(q),
      .wr_en  (we),
      .wr_addr(addr_q[AW-1:2]),
      .wr_data(wd)
   );

   always_ff @(posedge clock or negedge reset_l) begin
      if (!reset_l) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         cnt       <= '0;
         size_q    <= SZ_WORD;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               req_ready <= 1'b0;
               size_q    <= size_e'(req_size);
               addr_q    <= req_addr[AW-1:0];
               wdata_q   <= req_wdata;
               rsp_err   <= bad;
               cnt       <= '0;
               rsp_valid <= bad;
               state     <= bad ? RESP : !req_wr ? RD_WAIT : (req_size == 2'b00) ? WR : RMW_RD;
            end
            RD_WAIT: if (cnt == RW) begin
               rsp_rdata <= rd_val;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end else cnt <= cnt + 4'd1;
            RMW_RD: state <= RMW_WR;
            RMW_WR, WR: begin
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               rsp_rdata <= '0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed plus random transactions checked against a byte-array memory model
module tb_mem_responder;

   logic        clock = 1'b0;
   logic        reset_l;
   logic        req_valid, req_ready, req_wr, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata, rsp_rdata;

   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] mb [0:63];

   always #5 clock = ~clock;

   mem_responder #(.DEPTH_LOG2(8), .READ_WAIT(2), .INIT_FILE("")) dut (
      .clock(clock), .reset_l(reset_l),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_size(req_size),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction; expectations come from the byte model and the latency rules
   task automatic txn(input string tag, input bit wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wdat, output logic [31:0] rd);
      int nb, lat, exp_lat;
      bit err;
      logic [31:0] exp_rd;
      nb = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      err = (sz == 2'd3) || (a % nb != 0) || (a >= 32'h400);
      exp_rd = '0;
      if (err) exp_lat = 1;
      else if (wr) exp_lat = (nb == 4) ? 2 : 3;
      else exp_lat = 4;
      if (!err && !wr) for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = mb[int'(a) + i];
      if (!err && wr) for (int i = 0; i < nb; i++) mb[int'(a) + i] = wdat[8*i +: 8];
      @(negedge clock);
      chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wdat;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      rd = rsp_rdata;
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rsp_rdata, exp_rd);
      chk({tag, " err"}, 32'(rsp_err), 32'(err));
      chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  sz;
      logic [31:0] a;
      int w;
      reset_l = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset req_ready", 32'(req_ready), 32'd1);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      @(negedge clock);
      reset_l = 1'b1;
      for (int i = 0; i < 16; i++) txn("init", 1'b1, 2'd0, 32'(4 * i), 32'd0, rd);
      txn("sw deadbeef", 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, rd);
      txn("lw 10", 1'b0, 2'd0, 32'h10, 32'h0, rd);
      chk("lw 10 const", rd, 32'hDEADBEEF);
      txn("sb 55", 1'b1, 2'd2, 32'h12, 32'hFFFFFF55, rd);
      txn("lw 10 after sb", 1'b0, 2'd0, 32'h10, 32'h0, rd);
      chk("lw 10 after sb const", rd, 32'hDE55BEEF);
      txn("lbu 13", 1'b0, 2'd2, 32'h13, 32'h0, rd);
      chk("lbu 13 const", rd, 32'h000000DE);
      txn("sh 1234", 1'b1, 2'd1, 32'h16, 32'hABCD1234, rd);
      txn("lh 16", 1'b0, 2'd1, 32'h16, 32'h0, rd);
      chk("lh 16 const", rd, 32'h00001234);
      txn("lw 14", 1'b0, 2'd0, 32'h14, 32'h0, rd);
      chk("lw 14 const", rd, 32'h12340000);
      txn("err lw 11", 1'b0, 2'd0, 32'h11, 32'h0, rd);
      txn("err sh 03", 1'b1, 2'd1, 32'h03, 32'h5555, rd);
      txn("err size11", 1'b1, 2'd3, 32'h10, 32'h0, rd);
      txn("err lw 400", 1'b0, 2'd0, 32'h400, 32'h0, rd);
      txn("err sw 400", 1'b1, 2'd0, 32'h400, 32'hFFFFFFFF, rd);
      txn("lw 00 untouched", 1'b0, 2'd0, 32'h00, 32'h0, rd);
      txn("lw 10 untouched", 1'b0, 2'd0, 32'h10, 32'h0, rd);
      txn("lw 00 after sh03", 1'b0, 2'd0, 32'h00, 32'h0, rd);
      // Back-pressure: response must hold and a new request must be ignored
      @(negedge clock);
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd0; req_addr = 32'h10;
      @(posedge clock); #1;
      req_valid = 1'b0;
      w = 0;
      while (!rsp_valid && w < 40) begin
         @(posedge clock); #1;
         w++;
      end
      chk("hold rsp_valid seen", 32'(rsp_valid), 32'd1);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd0; req_addr = 32'h10; req_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock); #1;
         chk("hold rsp_valid", 32'(rsp_valid), 32'd1);
         chk("hold rsp_rdata", rsp_rdata, 32'hDE55BEEF);
         chk("hold req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      txn("lw 10 after hold", 1'b0, 2'd0, 32'h10, 32'h0, rd);
      chk("lw 10 after hold const", rd, 32'hDE55BEEF);
      // Reset landing in RMW_RD of a byte store must drop the store
      @(negedge clock);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2; req_addr = 32'h11; req_wdata = 32'hAA;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset_l = 1'b0;
      #1;
      chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort req_ready", 32'(req_ready), 32'd1);
      @(negedge clock);
      reset_l = 1'b1;
      txn("lw 10 after abort", 1'b0, 2'd0, 32'h10, 32'h0, rd);
      chk("lw 10 after abort const", rd, 32'hDE55BEEF);
      for (int i = 0; i < 150; i++) begin
         sz = 2'($urandom_range(0, 3));
         a = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
         txn("rand", 1'($urandom_range(0, 1)), sz, a, $urandom, rd);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
